// File: rtl/ifu.sv
// ifu: instruction fetch unit bridging fetch-stage commands to a single-outstanding system bus read.
// Aligned commands go IDLE -> REQ -> (RESP) -> IDLE; misaligned ones are flagged and dropped.
module ifu (
   input  logic        clk,
   input  logic        nrst,
   input  logic [31:0] i_addr,
   input  logic        i_rd_cmd,
   output logic [31:0] o_instr_dat,
   output logic        o_busy,
   output logic        o_err_align,
   output logic        o_err_bus,
   output logic [31:0] o_bus_addr,
   output logic        o_bus_rd,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_rvalid,
   input  logic        i_bus_err
);
   localparam int CPU_ADDR_WIDTH  = 32;
   localparam int CPU_INSTR_WIDTH = 32;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t                     state_q, state_d;
   logic [CPU_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [CPU_INSTR_WIDTH-1:0] instr_q, instr_d;
   logic                       err_q, err_d;
   logic                       cmd_ok, done;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         instr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         err_q   <= err_d;
      end
   end

   // A same-cycle ack+rvalid in REQ completes the fetch without visiting RESP.
   always_comb begin
      cmd_ok  = state_q == IDLE && i_rd_cmd && i_addr[1:0] == 2'b00;
      done    = (state_q == REQ && i_bus_ack && i_bus_rvalid) || (state_q == RESP && i_bus_rvalid);
      state_d = cmd_ok ? REQ : done ? IDLE : (state_q == REQ && i_bus_ack) ? RESP : state_q;
      addr_d  = cmd_ok ? i_addr : addr_q;
      instr_d = done ? (i_bus_err ? '0 : i_bus_rdata) : instr_q;
      err_d   = done && i_bus_err;
   end

   assign o_instr_dat = instr_q;
   assign o_bus_addr  = addr_q;
   assign o_err_bus   = err_q;
   assign o_bus_rd    = state_q == REQ;
   assign o_busy      = cmd_ok || state_q != IDLE;
   assign o_err_align = state_q == IDLE && i_rd_cmd && i_addr[1:0] != 2'b00;
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed checks of the fetch unit; inputs change on the falling edge,
// outputs are checked 1 ns later so every check sits between rising edges.
module tb_ifu;
   logic        clk = 1'b0;
   logic        nrst;
   logic [31:0] i_addr;
   logic        i_rd_cmd;
   logic [31:0] o_instr_dat;
   logic        o_busy;
   logic        o_err_align;
   logic        o_err_bus;
   logic [31:0] o_bus_addr;
   logic        o_bus_rd;
   logic        i_bus_ack;
   logic [31:0] i_bus_rdata;
   logic        i_bus_rvalid;
   logic        i_bus_err;
   int          total = 0;
   int          bad   = 0;

   ifu dut (
      .clk(clk), .nrst(nrst), .i_addr(i_addr), .i_rd_cmd(i_rd_cmd),
      .o_instr_dat(o_instr_dat), .o_busy(o_busy), .o_err_align(o_err_align),
      .o_err_bus(o_err_bus), .o_bus_addr(o_bus_addr), .o_bus_rd(o_bus_rd),
      .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .i_bus_rvalid(i_bus_rvalid),
      .i_bus_err(i_bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt;
      @(negedge clk);
   endtask

   task automatic bus(input logic ack, input logic rv, input logic err, input logic [31:0] d);
      i_bus_ack = ack; i_bus_rvalid = rv; i_bus_err = err; i_bus_rdata = d;
   endtask

   initial begin
      nrst = 1'b0; i_addr = '0; i_rd_cmd = 1'b0;
      bus(1'b0, 1'b0, 1'b0, 32'h0);
      nxt; #1;
      chk("rst_instr", o_instr_dat, 32'h0);
      chk("rst_addr",  o_bus_addr,  32'h0);
      chk("rst_rd",    {31'b0, o_bus_rd},  32'h0);
      chk("rst_busy",  {31'b0, o_busy},    32'h0);
      chk("rst_errb",  {31'b0, o_err_bus}, 32'h0);
      nxt; nrst = 1'b1;

      // aligned fetch, zero wait states
      nxt; i_rd_cmd = 1'b1; i_addr = 32'h0000_0100; #1;
      chk("al_busy0", {31'b0, o_busy}, 32'h1);
      chk("al_rd0",   {31'b0, o_bus_rd}, 32'h0);
      chk("al_ea0",   {31'b0, o_err_align}, 32'h0);
      nxt; i_rd_cmd = 1'b0; bus(1'b1, 1'b1, 1'b0, 32'h2408_0005); #1;
      chk("al_busy1", {31'b0, o_busy}, 32'h1);
      chk("al_rd1",   {31'b0, o_bus_rd}, 32'h1);
      chk("al_addr",  o_bus_addr, 32'h0000_0100);
      nxt; bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("al_busy2", {31'b0, o_busy}, 32'h0);
      chk("al_rd2",   {31'b0, o_bus_rd}, 32'h0);
      chk("al_data",  o_instr_dat, 32'h2408_0005);
      chk("al_errb",  {31'b0, o_err_bus}, 32'h0);

      // misaligned fetch
      nxt; i_rd_cmd = 1'b1; i_addr = 32'h0000_0102; #1;
      chk("mis_ea",   {31'b0, o_err_align}, 32'h1);
      chk("mis_busy", {31'b0, o_busy}, 32'h0);
      nxt; i_rd_cmd = 1'b0; #1;
      chk("mis_ea1",  {31'b0, o_err_align}, 32'h0);
      chk("mis_rd",   {31'b0, o_bus_rd}, 32'h0);
      chk("mis_busy1",{31'b0, o_busy}, 32'h0);
      chk("mis_addr", o_bus_addr, 32'h0000_0100);

      // bus error response
      nxt; i_rd_cmd = 1'b1; i_addr = 32'h0000_0400;
      nxt; i_rd_cmd = 1'b0; bus(1'b1, 1'b1, 1'b1, 32'h1234_5678);
      nxt; bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("be_instr", o_instr_dat, 32'h0);
      chk("be_errb",  {31'b0, o_err_bus}, 32'h1);
      chk("be_busy",  {31'b0, o_busy}, 32'h0);
      chk("be_rd",    {31'b0, o_bus_rd}, 32'h0);
      nxt; #1;
      chk("be_errb1", {31'b0, o_err_bus}, 32'h0);

      // wait states: ack after 3 REQ cycles, rvalid 2 cycles after ack
      nxt; i_rd_cmd = 1'b1; i_addr = 32'h0000_0200;
      nxt; i_rd_cmd = 1'b0; #1;
      chk("ws_rd1", {31'b0, o_bus_rd}, 32'h1);
      nxt; bus(1'b0, 1'b1, 1'b0, 32'hBAD0_BAD0); #1;
      chk("ws_rd2", {31'b0, o_bus_rd}, 32'h1);
      nxt; bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("ws_rd3", {31'b0, o_bus_rd}, 32'h1);
      chk("ws_ign", o_instr_dat, 32'h0);
      nxt; bus(1'b1, 1'b0, 1'b0, 32'h0); #1;
      chk("ws_rd4", {31'b0, o_bus_rd}, 32'h1);
      nxt; bus(1'b0, 1'b0, 1'b0, 32'h0); i_rd_cmd = 1'b1; i_addr = 32'h0000_0302; #1;
      chk("ws_rd5",   {31'b0, o_bus_rd}, 32'h0);
      chk("ws_busy5", {31'b0, o_busy}, 32'h1);
      chk("ws_ea5",   {31'b0, o_err_align}, 32'h0);
      nxt; i_rd_cmd = 1'b0; bus(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF); #1;
      chk("ws_busy6", {31'b0, o_busy}, 32'h1);
      chk("ws_addr6", o_bus_addr, 32'h0000_0200);
      nxt; bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("ws_busy7", {31'b0, o_busy}, 32'h0);
      chk("ws_data",  o_instr_dat, 32'hDEAD_BEEF);

      // stray bus activity in IDLE
      nxt; bus(1'b1, 1'b1, 1'b0, 32'h5555_5555);
      nxt; bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("idle_data", o_instr_dat, 32'hDEAD_BEEF);
      chk("idle_busy", {31'b0, o_busy}, 32'h0);
      chk("idle_rd",   {31'b0, o_bus_rd}, 32'h0);

      // reset asserted in REQ, then a late response
      nxt; i_rd_cmd = 1'b1; i_addr = 32'h0000_0500;
      nxt; i_rd_cmd = 1'b0; #1;
      chk("rr_rd", {31'b0, o_bus_rd}, 32'h1);
      nrst = 1'b0; #1;
      chk("rr_rd0",    {31'b0, o_bus_rd}, 32'h0);
      chk("rr_busy0",  {31'b0, o_busy}, 32'h0);
      chk("rr_addr0",  o_bus_addr, 32'h0);
      chk("rr_instr0", o_instr_dat, 32'h0);
      nxt; nrst = 1'b1; bus(1'b1, 1'b1, 1'b1, 32'h0000_0077);
      nxt; bus(1'b0, 1'b0, 1'b0, 32'h0); #1;
      chk("rr_instr1", o_instr_dat, 32'h0);
      chk("rr_errb1",  {31'b0, o_err_bus}, 32'h0);
      chk("rr_busy1",  {31'b0, o_busy}, 32'h0);
      chk("rr_rd1",    {31'b0, o_bus_rd}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
